// File: rtl/delay_timer_arbiter_pkg.sv
// Shared encodings for the delay timer arbiter: FSM states and the counter
// park value driven while no delay is in progress.
package delay_timer_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] CNT_PARK = 2'd0;

endpackage

// File: rtl/delay_timer_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. The pointer names the favoured requester
// on a tie and always moves to the index that was not granted.
module rr_arb2
    import delay_timer_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    logic ptr_q;
    logic ptr_d;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_idx_o   = 1'b0;
        ptr_d       = ptr_q;
        if (req_i == 2'b11) begin
            gnt_idx_o = ptr_q;
        end else begin
            gnt_idx_o = req_i[1];
        end
        if (en_i && gnt_valid_o) begin
            ptr_d = ~gnt_idx_o;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/delay_timer_arbiter.sv
// Shares one 2-bit loadable up-counter as a programmable delay timer between
// two requesters; acks the granted requester after R carry pulses.
module delay_timer_arbiter
    import delay_timer_arbiter_pkg::*;
#(
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [1:0]    pre0,
    input  logic [RW-1:0] rounds0,
    input  logic          req1,
    input  logic [1:0]    pre1,
    input  logic [RW-1:0] rounds1,
    input  logic          cnt_carry,
    output logic          cnt_ld,
    output logic [1:0]    cnt_data,
    output logic          ack0,
    output logic          ack1,
    output logic          busy,
    output logic          gnt_id
);

    logic [1:0]    state_q,  state_d;
    logic [1:0]    pre_q,    pre_d;
    logic [RW-1:0] rounds_q, rounds_d;
    logic [RW-1:0] rem_q,    rem_d;
    logic          gnt_q,    gnt_d;

    logic          cnt_ld_q,   cnt_ld_d;
    logic [1:0]    cnt_data_q, cnt_data_d;
    logic          ack0_q,     ack0_d;
    logic          ack1_q,     ack1_d;
    logic          busy_q,     busy_d;

    logic          arb_valid;
    logic          arb_idx;
    logic [1:0]    sel_pre;
    logic [RW-1:0] sel_rounds;

    rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst),
        .req_i       ({req1, req0}),
        .en_i        (state_q == ST_IDLE),
        .gnt_valid_o (arb_valid),
        .gnt_idx_o   (arb_idx)
    );

    assign sel_pre    = arb_idx ? pre1    : pre0;
    assign sel_rounds = arb_idx ? rounds1 : rounds0;

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        rounds_d = rounds_q;
        rem_d    = rem_q;
        gnt_d    = gnt_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d    = arb_idx;
                    pre_d    = sel_pre;
                    rounds_d = sel_rounds;
                    // A zero-round request needs no counting at all.
                    state_d  = (sel_rounds == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                rem_d   = rounds_q;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_carry) begin
                    if (rem_q == RW'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        rem_d = rem_q - RW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they appear registered
        // in the same cycle as the state they describe.
        cnt_ld_d   = (state_d != ST_WAIT);
        cnt_data_d = (state_d == ST_LOAD) ? pre_d : CNT_PARK;
        ack0_d     = (state_d == ST_DONE) && !gnt_d;
        ack1_d     = (state_d == ST_DONE) &&  gnt_d;
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            rounds_q   <= '0;
            rem_q      <= '0;
            gnt_q      <= 1'b0;
            cnt_ld_q   <= 1'b1;
            cnt_data_q <= CNT_PARK;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            rounds_q   <= rounds_d;
            rem_q      <= rem_d;
            gnt_q      <= gnt_d;
            cnt_ld_q   <= cnt_ld_d;
            cnt_data_q <= cnt_data_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
        end
    end

    assign cnt_ld   = cnt_ld_q;
    assign cnt_data = cnt_data_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign busy     = busy_q;
    assign gnt_id   = gnt_q;

endmodule
